// File: rtl/reduction_lut_loader.sv
// Streams IN_WIDTH-bit host words into LUT_WIDTH-bit entries and writes them
// sequentially into NUM_ROMS reduction table RAMs, then reports done.
module reduction_lut_loader #(
  parameter int WORD_LEN              = 16,
  parameter int NONREDUNDANT_ELEMENTS = 64,
  parameter int LOOK_UP_WIDTH         = 8,
  parameter int NUM_ROMS              = 33,
  parameter int IN_WIDTH              = 32,
  localparam int LUT_WIDTH            = WORD_LEN * NONREDUNDANT_ELEMENTS,
  localparam int NUM_LUT_ENTRIES      = 2 ** (LOOK_UP_WIDTH + 1),
  localparam int BEATS                = LUT_WIDTH / IN_WIDTH,
  localparam int SEL_W                = (NUM_ROMS > 1) ? $clog2(NUM_ROMS) : 1,
  localparam int ADDR_W               = LOOK_UP_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 wr_en,
  output logic [SEL_W-1:0]     wr_sel,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [LUT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_LUT_ENTRIES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_ROMS - 1);

  if (LUT_WIDTH % IN_WIDTH != 0) begin : g_width_check
    $error("reduction_lut_loader: LUT_WIDTH must be a multiple of IN_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                state, state_next;
  logic [BEAT_W-1:0]     beat;
  logic [ADDR_W-1:0]     addr;
  logic [SEL_W-1:0]      sel;
  logic [LUT_WIDTH-1:0]  pack, pack_next;
  logic                  xfer, last_beat, last_entry;

  assign s_ready    = (state == LOAD);
  assign wr_en      = (state == WRITE);
  assign busy       = (state == LOAD) || (state == WRITE);
  assign done       = (state == DONE);
  assign xfer       = s_ready && s_valid;
  assign last_beat  = (beat == BEAT_LAST);
  assign last_entry = (sel == SEL_LAST) && (addr == ADDR_LAST);

  // Entry with the current beat merged in, so the final beat can be captured
  // straight into wr_data without waiting a cycle for pack to settle.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so no path leaves pack_next unassigned and no latch is inferred.
    pack_next = pack;
    if (xfer) pack_next[beat*IN_WIDTH +: IN_WIDTH] = s_data;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = LOAD;
      LOAD:       if (xfer && last_beat) state_next = WRITE;
      WRITE:      state_next = last_entry ? DONE : LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      addr    <= '0;
      sel     <= '0;
      pack    <= '0;
      wr_sel  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            beat <= '0;
            addr <= '0;
            sel  <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            pack <= pack_next;
            if (last_beat) begin
              beat    <= '0;
              wr_data <= pack_next;
              wr_sel  <= sel;
              wr_addr <= addr;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        WRITE: begin
          // Address wraps at the end of a RAM and moves on to the next table.
          if (addr == ADDR_LAST) begin
            addr <= '0;
            sel  <= sel + 1'b1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
